// File: rtl/fsm_tb_pkg.sv
// Shared constants and types for the fsm test harness.
//   OUT_W     : width of the fsm out vector and of the expected vector
//   IN_W      : width of the fsm input vector driven by the golden sequence
//   DEPTH     : beats per run, one per input_sequence entry
//   CNT_W     : beat index / mismatch counter width (2**CNT_W > DEPTH)
//   MISR_POLY : default MISR feedback taps, x^19+x^5+x^2+x+1
//   state_t   : response checker run state
package fsm_tb_pkg;

   localparam int OUT_W = 19;
   localparam int IN_W  = 8;
   localparam int DEPTH = 110;
   localparam int CNT_W = 7;

   localparam logic [OUT_W-1:0] MISR_POLY = 19'h00027;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fsm_resp_checker_misr.sv
// resp_misr: multiple-input signature register that compacts one response
// vector per enabled cycle into a running signature.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous reset, active-low, clears the signature
//   clr : synchronous clear, takes priority over en
//   en  : fold d into the signature this cycle
//   d   : response vector to compact
//   sig : current signature
module resp_misr #(
   parameter int               OUT_W = 19,
   parameter logic [OUT_W-1:0] POLY  = 19'h00027
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [OUT_W-1:0] d,
   output logic [OUT_W-1:0] sig
);

   // Galois-style shift: the bit falling off the top folds the feedback taps
   // back in, then the new response is XORed across the whole word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? POLY : '0) ^ d;
      end
   end

endmodule

// File: rtl/fsm_resp_checker.sv
// fsm_resp_checker: downstream stage of the fsm under test. Compares each
// valid response beat against the expected vector, counts mismatches,
// captures the first failing beat and gives one pass/fail verdict per run
// of DEPTH beats.
// Optional feature macro: RESP_CHECKER_MISR_EN adds a MISR signature of
// every accepted response; without it signature is tied to 0.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-low
//   start      : begin or restart a run (1-cycle pulse)
//   resp_valid : resp/exp carry a valid beat this cycle
//   resp       : fsm out vector
//   exp        : expected out vector for the same beat
//   busy       : run in progress
//   done       : run complete, held until the next start
//   pass       : done with zero mismatches
//   mism_cnt   : mismatching beats, saturating at all-ones
//   first_idx  : 0-based beat index of the first mismatch
//   first_resp : resp value at the first mismatch
//   signature  : MISR value, or 0 when the MISR is not built
module fsm_resp_checker #(
   parameter int                          OUT_W = fsm_tb_pkg::OUT_W,
   parameter int                          DEPTH = fsm_tb_pkg::DEPTH,
   parameter int                          CNT_W = fsm_tb_pkg::CNT_W,
   parameter logic [fsm_tb_pkg::OUT_W-1:0] POLY = fsm_tb_pkg::MISR_POLY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             resp_valid,
   input  logic [OUT_W-1:0] resp,
   input  logic [OUT_W-1:0] exp,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mism_cnt,
   output logic [CNT_W-1:0] first_idx,
   output logic [OUT_W-1:0] first_resp,
   output logic [OUT_W-1:0] signature
);

   import fsm_tb_pkg::*;

   // The beat index must reach DEPTH-1 even when CNT_W is too narrow for it,
   // so it gets its own width; first_idx reports the low CNT_W bits.
   localparam int IDX_W = ($clog2(DEPTH) > CNT_W) ? $clog2(DEPTH) : CNT_W;

   state_t           state;
   state_t           stateNext;
   logic [IDX_W-1:0] idx;
   logic             passQ;
   logic             beat;
   logic             lastBeat;
   logic             mismatch;

   // A beat only counts while running and when no start competes with it.
   assign beat     = (state == RUN) && resp_valid && !start;
   assign lastBeat = (idx == IDX_W'(DEPTH - 1));
   assign mismatch = (resp != exp);

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign pass = passQ && done;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic: start from anywhere (re)enters RUN, the last accepted
   // beat of the run moves to DONE.
   always_comb begin
      stateNext = state;
      if (start) begin
         stateNext = RUN;
      end else if (beat && lastBeat) begin
         stateNext = DONE;
      end
   end

   // Beat counters and first-failure capture. The verdict is formed on the
   // last beat using that beat's own compare, so it lands together with done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx        <= '0;
         mism_cnt   <= '0;
         first_idx  <= '0;
         first_resp <= '0;
         passQ      <= 1'b0;
      end else if (start) begin
         idx        <= '0;
         mism_cnt   <= '0;
         first_idx  <= '0;
         first_resp <= '0;
         passQ      <= 1'b0;
      end else if (beat) begin
         idx <= idx + IDX_W'(1);
         if (mismatch) begin
            if (mism_cnt == '0) begin
               first_idx  <= idx[CNT_W-1:0];
               first_resp <= resp;
            end
            if (mism_cnt != '1) begin
               mism_cnt <= mism_cnt + CNT_W'(1);
            end
         end
         if (lastBeat) begin
            passQ <= (mism_cnt == '0) && !mismatch;
         end
      end
   end

`ifdef RESP_CHECKER_MISR_EN
   // Signature is cleared by start and only advances on accepted beats, so
   // it stays frozen in IDLE and DONE.
   resp_misr #(
      .OUT_W (OUT_W),
      .POLY  (POLY)
   ) u_misr (
      .clk (clk),
      .rst (rst),
      .clr (start),
      .en  (beat),
      .d   (resp),
      .sig (signature)
   );
`else
   logic unusedPoly;

   // Without the MISR the taps have no consumer and the signature reads 0.
   assign unusedPoly = ^POLY;
   assign signature  = '0;
`endif

endmodule

// File: tb/tb_fsm_resp_checker.sv
// tb_fsm_resp_checker: directed self-checking bench for fsm_resp_checker.
// A second instance with DEPTH=130 exercises mismatch counter saturation.
// Expected signature values are only non-zero when RESP_CHECKER_MISR_EN is
// defined for the build.
module tb_fsm_resp_checker;

   localparam int OUT_W = 19;
   localparam int CNT_W = 7;
   localparam logic [OUT_W-1:0] POLY = 19'h00027;

   logic             clk;
   logic             rst;
   logic             start;
   logic             respValid;
   logic [OUT_W-1:0] resp;
   logic [OUT_W-1:0] exp;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] mismCnt;
   logic [CNT_W-1:0] firstIdx;
   logic [OUT_W-1:0] firstResp;
   logic [OUT_W-1:0] signature;

   logic             sStart;
   logic             sRespValid;
   logic [OUT_W-1:0] sResp;
   logic [OUT_W-1:0] sExp;
   logic             sBusy;
   logic             sDone;
   logic             sPass;
   logic [CNT_W-1:0] sMismCnt;
   logic [CNT_W-1:0] sFirstIdx;
   logic [OUT_W-1:0] sFirstResp;
   logic [OUT_W-1:0] sSignature;

   int checkCount = 0;
   int errCount   = 0;

   fsm_resp_checker #(
      .OUT_W (OUT_W),
      .DEPTH (110),
      .CNT_W (CNT_W),
      .POLY  (POLY)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .resp_valid (respValid),
      .resp       (resp),
      .exp        (exp),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .mism_cnt   (mismCnt),
      .first_idx  (firstIdx),
      .first_resp (firstResp),
      .signature  (signature)
   );

   fsm_resp_checker #(
      .OUT_W (OUT_W),
      .DEPTH (130),
      .CNT_W (CNT_W),
      .POLY  (POLY)
   ) u_sat (
      .clk        (clk),
      .rst        (rst),
      .start      (sStart),
      .resp_valid (sRespValid),
      .resp       (sResp),
      .exp        (sExp),
      .busy       (sBusy),
      .done       (sDone),
      .pass       (sPass),
      .mism_cnt   (sMismCnt),
      .first_idx  (sFirstIdx),
      .first_resp (sFirstResp),
      .signature  (sSignature)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Software MISR used as the golden signature model.
   function automatic logic [OUT_W-1:0] misrStep(input logic [OUT_W-1:0] s,
                                                 input logic [OUT_W-1:0] d);
      return {s[OUT_W-2:0], 1'b0} ^ (s[OUT_W-1] ? POLY : '0) ^ d;
   endfunction

   function automatic logic [OUT_W-1:0] expectSig(input logic [OUT_W-1:0] model);
`ifdef RESP_CHECKER_MISR_EN
      return model;
`else
      return (model & '0);
`endif
   endfunction

   // Advance one clock and settle 1 ns past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic driveBeat(input logic [OUT_W-1:0] r, input logic [OUT_W-1:0] e);
      resp      = r;
      exp       = e;
      respValid = 1'b1;
      tick();
      respValid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      checkCount++;
      if ({busy, done, pass, mismCnt, firstIdx, firstResp, signature} !== '0) begin
         errCount++;
         $display("[TB] FAIL reset_outputs: got busy=%b done=%b pass=%b mism=%0d fidx=%0d fresp=%h sig=%h required all 0",
                  busy, done, pass, mismCnt, firstIdx, firstResp, signature);
      end
      tick();
      rst = 1'b1;
      tick();
      checkCount++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errCount++;
         $display("[TB] FAIL idle_after_reset: got busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_all_match();
      pulseStart();
      checkCount++;
      if (busy !== 1'b1) begin
         errCount++;
         $display("[TB] FAIL match_busy: got %b required 1", busy);
      end
      for (int i = 0; i < 110; i++) begin
         driveBeat(OUT_W'(i * 3 + 7), OUT_W'(i * 3 + 7));
         if (i == 108) begin
            checkCount++;
            if (done !== 1'b0 || busy !== 1'b1 || pass !== 1'b0) begin
               errCount++;
               $display("[TB] FAIL match_early_done: got done=%b busy=%b pass=%b required 0 1 0", done, busy, pass);
            end
         end
      end
      checkCount++;
      if (done !== 1'b1 || pass !== 1'b1 || mismCnt !== 7'd0 || busy !== 1'b0) begin
         errCount++;
         $display("[TB] FAIL match_verdict: got done=%b pass=%b mism=%0d busy=%b required 1 1 0 0",
                  done, pass, mismCnt, busy);
      end
   endtask

   task automatic test_mismatch();
      logic [OUT_W-1:0] r;
      logic [OUT_W-1:0] beat5;
      beat5 = '0;
      pulseStart();
      checkCount++;
      if (done !== 1'b0 || pass !== 1'b0) begin
         errCount++;
         $display("[TB] FAIL restart_clears_done: got done=%b pass=%b required 0 0", done, pass);
      end
      for (int i = 0; i < 110; i++) begin
         r = OUT_W'(i) ^ 19'h5a5a0;
         if (i == 5) beat5 = r;
         driveBeat(r, (i == 5 || i == 40) ? (r ^ 19'h00001) : r);
         if (i == 5) begin
            checkCount++;
            if (mismCnt !== 7'd1 || firstIdx !== 7'd5) begin
               errCount++;
               $display("[TB] FAIL mism_first_beat: got mism=%0d fidx=%0d required 1 5", mismCnt, firstIdx);
            end
         end
      end
      checkCount++;
      if (mismCnt !== 7'd2 || firstIdx !== 7'd5 || firstResp !== beat5) begin
         errCount++;
         $display("[TB] FAIL mism_capture: got mism=%0d fidx=%0d fresp=%h required 2 5 %h",
                  mismCnt, firstIdx, firstResp, beat5);
      end
      checkCount++;
      if (done !== 1'b1 || pass !== 1'b0) begin
         errCount++;
         $display("[TB] FAIL mism_verdict: got done=%b pass=%b required 1 0", done, pass);
      end
   endtask

   task automatic test_gaps();
      pulseStart();
      for (int i = 0; i < 110; i++) begin
         driveBeat(OUT_W'(i + 100), OUT_W'(i + 100));
         if (i == 10) begin
            for (int g = 0; g < 3; g++) begin
               resp = 19'h7ffff;
               exp  = 19'h00000;
               tick();
            end
            checkCount++;
            if (busy !== 1'b1 || mismCnt !== 7'd0) begin
               errCount++;
               $display("[TB] FAIL gap_ignored: got busy=%b mism=%0d required 1 0", busy, mismCnt);
            end
         end
         if (i == 108) begin
            checkCount++;
            if (done !== 1'b0) begin
               errCount++;
               $display("[TB] FAIL gap_early_done: got %b required 0", done);
            end
         end
      end
      checkCount++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         errCount++;
         $display("[TB] FAIL gap_verdict: got done=%b pass=%b required 1 1", done, pass);
      end
   endtask

   task automatic test_restart();
      pulseStart();
      for (int i = 0; i < 50; i++) begin
         driveBeat(OUT_W'(i + 1), 19'h00000);
      end
      checkCount++;
      if (mismCnt !== 7'd50) begin
         errCount++;
         $display("[TB] FAIL restart_pre_count: got %0d required 50", mismCnt);
      end
      // start and a mismatching beat together: the beat must be dropped
      resp      = 19'h12345;
      exp       = 19'h00000;
      respValid = 1'b1;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      respValid = 1'b0;
      checkCount++;
      if (mismCnt !== 7'd0 || firstIdx !== 7'd0 || firstResp !== 19'h0 || busy !== 1'b1) begin
         errCount++;
         $display("[TB] FAIL restart_clear: got mism=%0d fidx=%0d fresp=%h busy=%b required 0 0 0 1",
                  mismCnt, firstIdx, firstResp, busy);
      end
      for (int i = 0; i < 110; i++) begin
         driveBeat(OUT_W'(i * 5), OUT_W'(i * 5));
         if (i == 108) begin
            checkCount++;
            if (done !== 1'b0) begin
               errCount++;
               $display("[TB] FAIL restart_early_done: got %b required 0", done);
            end
         end
      end
      checkCount++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         errCount++;
         $display("[TB] FAIL restart_verdict: got done=%b pass=%b required 1 1", done, pass);
      end
   endtask

   task automatic test_async_reset();
      pulseStart();
      for (int i = 0; i < 5; i++) begin
         driveBeat(OUT_W'(i + 9), 19'h00000);
      end
      #2;
      rst = 1'b0;
      #1;
      checkCount++;
      if ({busy, done, pass, mismCnt, firstIdx, firstResp, signature} !== '0) begin
         errCount++;
         $display("[TB] FAIL async_reset: got busy=%b done=%b pass=%b mism=%0d fidx=%0d fresp=%h sig=%h required all 0",
                  busy, done, pass, mismCnt, firstIdx, firstResp, signature);
      end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_saturate();
      sStart = 1'b1;
      tick();
      sStart = 1'b0;
      for (int i = 0; i < 130; i++) begin
         sResp      = OUT_W'(i + 1);
         sExp       = 19'h00000;
         sRespValid = 1'b1;
         tick();
         sRespValid = 1'b0;
         if (i == 126 || i == 127) begin
            checkCount++;
            if (sMismCnt !== 7'd127 || sBusy !== 1'b1) begin
               errCount++;
               $display("[TB] FAIL sat_reach beat %0d: got mism=%0d busy=%b required 127 1", i, sMismCnt, sBusy);
            end
         end
      end
      checkCount++;
      if (sMismCnt !== 7'd127 || sDone !== 1'b1 || sPass !== 1'b0 || sFirstIdx !== 7'd0 || sFirstResp !== 19'h1) begin
         errCount++;
         $display("[TB] FAIL sat_final: got mism=%0d done=%b pass=%b fidx=%0d fresp=%h required 127 1 0 0 00001",
                  sMismCnt, sDone, sPass, sFirstIdx, sFirstResp);
      end
   endtask

   task automatic test_misr();
      logic [OUT_W-1:0] model;
      logic [OUT_W-1:0] r;
      logic [OUT_W-1:0] golden20;
      model = '0;
`ifdef RESP_CHECKER_MISR_EN
      golden20 = 19'h00027;
`else
      golden20 = 19'h00000;
`endif
      pulseStart();
      checkCount++;
      if (signature !== 19'h0) begin
         errCount++;
         $display("[TB] FAIL misr_clear: got %h required 00000", signature);
      end
      for (int i = 0; i < 110; i++) begin
         r = (i == 0) ? 19'h00001 : ((i < 20) ? 19'h00000 : OUT_W'(i * 11 + 3));
         model = misrStep(model, r);
         driveBeat(r, r);
         if (i == 19) begin
            checkCount++;
            if (signature !== golden20) begin
               errCount++;
               $display("[TB] FAIL misr_poly: got %h required %h", signature, golden20);
            end
         end
      end
      checkCount++;
      if (signature !== expectSig(model) || pass !== 1'b1) begin
         errCount++;
         $display("[TB] FAIL misr_run: got sig=%h pass=%b required %h 1", signature, pass, expectSig(model));
      end
      // beats in DONE are ignored and the signature stays frozen
      driveBeat(19'h3c3c3, 19'h00000);
      checkCount++;
      if (signature !== expectSig(model) || mismCnt !== 7'd0 || done !== 1'b1) begin
         errCount++;
         $display("[TB] FAIL misr_frozen: got sig=%h mism=%0d done=%b required %h 0 1",
                  signature, mismCnt, done, expectSig(model));
      end
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      respValid  = 1'b0;
      resp       = '0;
      exp        = '0;
      sStart     = 1'b0;
      sRespValid = 1'b0;
      sResp      = '0;
      sExp       = '0;
      test_reset();
      test_all_match();
      test_mismatch();
      test_gaps();
      test_restart();
      test_async_reset();
      test_saturate();
      test_misr();
      $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
      $finish;
   end

endmodule
